// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Splits 32-bit word writes / 64-bit line reads from the data cache
//            into 16-bit transfers to a 256Kx16 asynchronous SRAM.
// Options  : define SRAM_RANGE_CHECK_EN to reject addresses outside the SRAM
//            window and add the err output.
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [63:0] rdata,
   output logic        ready,
`ifdef SRAM_RANGE_CHECK_EN
   output logic        err,
`endif
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [2:0] c_wait_last = 3'(WAIT_CYCLES);

   state_t      state_q,     state_d;
   logic        is_wr_q,     is_wr_d;
   logic [1:0]  phase_q,     phase_d;
   logic [2:0]  wait_q,      wait_d;
   logic [17:0] sram_addr_q, sram_addr_d;
   logic [15:0] dq_out_q,    dq_out_d;
   logic        dq_oe_q,     dq_oe_d;
   logic [15:0] wdata_hi_q,  wdata_hi_d;
   logic [63:0] rdata_q,     rdata_d;
   logic        ready_q,     ready_d;
   logic        we_n_q,      we_n_d;
   logic        oe_n_q,      oe_n_d;
   logic        ce_n_q,      ce_n_d;

   logic [31:0] w_off;
   logic        w_reject;
   logic [1:0]  w_last_phase;
   logic        unused_off_bits;

   assign w_off           = address - BASE_ADDR;
   assign w_last_phase    = is_wr_q ? 2'd1 : 2'd3;
   assign unused_off_bits = ^{w_off[31:19], w_off[1:0]};

`ifdef SRAM_RANGE_CHECK_EN
   logic err_q, err_d;

   assign w_reject = (address < BASE_ADDR) || (|w_off[31:19]);
   assign err_d    = (state_q == ST_IDLE) && (read || write) && w_reject;
   assign err      = err_q;
`else
   assign w_reject = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      is_wr_d     = is_wr_q;
      phase_d     = phase_q;
      wait_d      = wait_q;
      sram_addr_d = sram_addr_q;
      dq_out_d    = dq_out_q;
      dq_oe_d     = dq_oe_q;
      wdata_hi_d  = wdata_hi_q;
      rdata_d     = rdata_q;
      ready_d     = 1'b0;
      we_n_d      = we_n_q;
      oe_n_d      = oe_n_q;
      ce_n_d      = ce_n_q;

      case (state_q)
         ST_IDLE: begin
            if (write || read) begin
               is_wr_d = write;
               phase_d = 2'd0;
               wait_d  = 3'd0;
               if (w_reject) begin
                  // Rejected request completes at once without touching the pins.
                  state_d = ST_DONE;
                  ready_d = 1'b1;
               end else begin
                  state_d = ST_ACCESS;
                  ce_n_d  = 1'b0;
                  we_n_d  = ~write;
                  oe_n_d  = write;
                  if (write) begin
                     sram_addr_d = {w_off[18:2], 1'b0};
                     dq_out_d    = wdata[15:0];
                     dq_oe_d     = 1'b1;
                     wdata_hi_d  = wdata[31:16];
                  end else begin
                     sram_addr_d = {w_off[18:3], 2'b00};
                  end
               end
            end
         end

         ST_ACCESS: begin
            if (wait_q == c_wait_last) begin
               wait_d = 3'd0;
               if (!is_wr_q) begin
                  rdata_d[{phase_q, 4'b0000} +: 16] = SRAM_DQ;
               end
               if (phase_q == w_last_phase) begin
                  state_d = ST_DONE;
                  ready_d = 1'b1;
                  ce_n_d  = 1'b1;
                  we_n_d  = 1'b1;
                  oe_n_d  = 1'b1;
                  dq_oe_d = 1'b0;
               end else begin
                  phase_d     = phase_q + 2'd1;
                  sram_addr_d = sram_addr_q + 18'd1;
                  dq_out_d    = wdata_hi_q;
               end
            end else begin
               wait_d = wait_q + 3'd1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         is_wr_q     <= 1'b0;
         phase_q     <= 2'd0;
         wait_q      <= 3'd0;
         sram_addr_q <= 18'd0;
         dq_out_q    <= 16'd0;
         dq_oe_q     <= 1'b0;
         wdata_hi_q  <= 16'd0;
         rdata_q     <= 64'd0;
         ready_q     <= 1'b0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         ce_n_q      <= 1'b1;
`ifdef SRAM_RANGE_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         is_wr_q     <= is_wr_d;
         phase_q     <= phase_d;
         wait_q      <= wait_d;
         sram_addr_q <= sram_addr_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         wdata_hi_q  <= wdata_hi_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
         ce_n_q      <= ce_n_d;
`ifdef SRAM_RANGE_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
   assign SRAM_ADDR = sram_addr_q;
   assign SRAM_WE_N = we_n_q;
   assign SRAM_OE_N = oe_n_q;
   assign SRAM_CE_N = ce_n_q;
   assign SRAM_UB_N = ce_n_q;
   assign SRAM_LB_N = ce_n_q;
   assign rdata     = rdata_q;
   assign ready     = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Randomized scoreboard bench for sram_controller with an SRAM
//            device model; honours SRAM_RANGE_CHECK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

   localparam int          WAIT = 1;
   localparam int          PH   = WAIT + 1;
   localparam logic [31:0] BASE = 32'd1024;
`ifdef SRAM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        tb_read;
   logic        tb_write;
   logic [31:0] tb_address;
   logic [31:0] tb_wdata;
   logic [63:0] rdata;
   logic        ready;
   wire  [15:0] SRAM_DQ;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
`ifdef SRAM_RANGE_CHECK_EN
   logic        err_o;
`endif

   sram_controller #(.WAIT_CYCLES(WAIT), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .rst       (rst),
      .read      (tb_read),
      .write     (tb_write),
      .address   (tb_address),
      .wdata     (tb_wdata),
      .rdata     (rdata),
      .ready     (ready),
`ifdef SRAM_RANGE_CHECK_EN
      .err       (err_o),
`endif
      .SRAM_DQ   (SRAM_DQ),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_UB_N (SRAM_UB_N),
      .SRAM_LB_N (SRAM_LB_N)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SRAM device: drives the bus whenever it is not being written, with a
   // fixed idle pattern when not selected for reading.
   logic [15:0] dev_mem [0:262143];
   logic [15:0] ref_mem [0:262143];
   logic [15:0] dev_out;

   assign dev_out = (!SRAM_CE_N && !SRAM_OE_N) ? dev_mem[SRAM_ADDR] : 16'h5AA5;
   assign SRAM_DQ = SRAM_WE_N ? dev_out : 16'hzzzz;

   always @(posedge clk) begin
      if (!SRAM_CE_N && !SRAM_WE_N) dev_mem[SRAM_ADDR] <= SRAM_DQ;
   end

   typedef struct {
      bit          is_wr;
      bit          exp_err;
      int          nph;
      logic [17:0] base;
      logic [31:0] wd;
      logic [63:0] exp_rdata;
   } item_t;

   typedef struct {
      logic [17:0] a;
      logic        we_n;
      logic        oe_n;
      logic        ub_n;
      logic        lb_n;
      logic [15:0] dq;
   } sample_t;

   item_t       sb[$];
   sample_t     log_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] last_rdata = 64'd0;
   bit          prev_ready = 1'b0;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic score(input item_t it);
      int          bad;
      int          ph;
      logic [15:0] edq;
      bad = 0;
      check(log_q.size() == it.nph * PH, "access_cycles", 64'(log_q.size()), 64'(it.nph * PH));
      foreach (log_q[i]) begin
         ph  = i / PH;
         edq = (ph == 0) ? it.wd[15:0] : it.wd[31:16];
         if (log_q[i].a != it.base + 18'(ph)) bad++;
         if (log_q[i].we_n != !it.is_wr || log_q[i].oe_n != it.is_wr) bad++;
         if (log_q[i].ub_n || log_q[i].lb_n) bad++;
         if (it.is_wr && log_q[i].dq != edq) bad++;
      end
      check(bad == 0, it.is_wr ? "write_trace" : "read_trace", 64'(bad), 64'd0);
      check(rdata == it.exp_rdata, it.is_wr ? "rdata_held" : "rdata_line", rdata, it.exp_rdata);
      check({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} == 5'h1F, "done_strobes",
            64'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 64'h1F);
`ifdef SRAM_RANGE_CHECK_EN
      check(err_o == it.exp_err, "err_flag", 64'(err_o), 64'(it.exp_err));
`endif
   endtask

   // Monitor: collects every selected SRAM cycle and scores on each ready.
   always @(negedge clk) begin
      if (rst) begin
         log_q.delete();
         prev_ready = 1'b0;
      end else begin
         if (prev_ready) check(ready == 1'b0, "ready_one_cycle", 64'(ready), 64'd0);
         if (!SRAM_CE_N)
            log_q.push_back('{SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ});
         if (ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready: actual 1, required 0");
            end else begin
               score(sb.pop_front());
            end
            log_q.delete();
         end
         prev_ready = ready;
      end
   end

   task automatic issue(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] wd);
      item_t       it;
      logic [31:0] off;
      int          n;
      @(negedge clk);
      off        = a - BASE;
      it.is_wr   = wr;
      it.wd      = wd;
      it.exp_err = 1'b0;
      if (RC && (a < BASE || off >= 32'h80000)) begin
         it.exp_err   = 1'b1;
         it.nph       = 0;
         it.base      = 18'd0;
         it.exp_rdata = last_rdata;
      end else if (wr) begin
         it.base             = 18'(((off / 4) * 2) % 32'h40000);
         ref_mem[it.base]    = wd[15:0];
         ref_mem[it.base + 1] = wd[31:16];
         it.nph              = 2;
         it.exp_rdata        = last_rdata;
      end else begin
         it.base      = 18'(((off / 8) * 4) % 32'h40000);
         it.nph       = 4;
         it.exp_rdata = {ref_mem[it.base + 3], ref_mem[it.base + 2],
                         ref_mem[it.base + 1], ref_mem[it.base]};
         last_rdata   = it.exp_rdata;
      end
      sb.push_back(it);
      tb_write   = wr;
      tb_read    = both | !wr;
      tb_address = a;
      tb_wdata   = wd;
      n = 0;
      while (!ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      check(ready == 1'b1, "ready_seen", 64'(n), 64'd0);
      tb_read  = 1'b0;
      tb_write = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      return BASE + 32'h80000 + 32'($urandom_range(0, 255));
      else if (r == 1) return BASE - 32'($urandom_range(1, 64));
      else             return BASE + 32'($urandom_range(0, 255));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      for (int i = 0; i < 262144; i++) begin
         dev_mem[i] = 16'(i * 40503) ^ 16'h1234;
         ref_mem[i] = 16'(i * 40503) ^ 16'h1234;
      end
      tb_read = 1'b0; tb_write = 1'b0; tb_address = 32'd0; tb_wdata = 32'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, ready} == 6'b111110
               && rdata == 64'd0 && SRAM_ADDR == 18'd0 && SRAM_DQ == 16'h5AA5, "reset_idle",
               {rdata[15:0], SRAM_DQ, 14'(SRAM_ADDR), 2'b00,
                SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, ready},
               {16'h0, 16'h5AA5, 16'h0, 10'b0, 6'b111110});
`ifdef SRAM_RANGE_CHECK_EN
         check(err_o == 1'b0, "reset_err", 64'(err_o), 64'd0);
`endif
      end

      issue(1'b1, 1'b0, 32'h414, 32'hDEADBEEF);
      issue(1'b0, 1'b0, 32'h410, 32'h0);
      check(rdata[63:32] == 32'hDEADBEEF, "line_upper_word", 64'(rdata[63:32]), 64'hDEADBEEF);
      issue(1'b1, 1'b1, 32'h420, 32'h13579BDF);
      issue(1'b0, 1'b0, 32'h420, 32'h0);
      issue(1'b0, 1'b0, 32'h3FC, 32'h0);

      // Abandon a read part-way through with an asynchronous reset.
      @(negedge clk);
      tb_read    = 1'b1;
      tb_address = BASE + 32'h40;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, ready} == 6'b111110,
            "reset_mid_strobes", 64'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, ready}),
            64'b111110);
      check(rdata == 64'd0, "reset_mid_rdata", rdata, 64'd0);
      tb_read = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      last_rdata = 64'd0;
      issue(1'b0, 1'b0, 32'h410, 32'h0);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      issue(1'b1, 1'b0, rand_addr(), $urandom);
         else if (r < 5) issue(1'b1, 1'b1, rand_addr(), $urandom);
         else            issue(1'b0, 1'b0, rand_addr(), 32'h0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_controller.md
# sram_controller

Sequences the off-chip 256K×16 SRAM on behalf of the data-cache controller. It accepts one 32-bit word write or one 64-bit line read per handshake. Each access is split into 16-bit SRAM transfers with a configurable number of wait cycles, and `ready` is pulsed for one cycle when the access completes. It sits between the cache controller's `read`/`write`/`sram_address`/`sram_wdata` outputs and the SRAM pins, and supplies the `sram_rdata`/`sram_ready` inputs of the cache controller.

## Interface
- `WAIT_CYCLES`, default 1: extra clock cycles held per 16-bit transfer (phase length = `WAIT_CYCLES`+1); range 0..7.
- `BASE_ADDR`, default 1024: CPU byte address mapped to SRAM halfword 0.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `read` in 1: line-read request; held high until `ready`.
- `write` in 1: word-write request; held high until `ready`.
- `address` in 32: CPU byte address, sampled in IDLE.
- `wdata` in 32: write word, sampled in IDLE.
- `rdata` out 64: last completed line.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: range-violation flag; present only with `SRAM_RANGE_CHECK_EN`.
- `SRAM_DQ` inout 16: data bus; driven only during write phases, otherwise high-Z.
- `SRAM_ADDR` out 18: halfword address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: active-low strobes.

## Operation
- **States:** IDLE, ACCESS, DONE.
- **IDLE:**
  - If `write`=1, latch a write; else if `read`=1, latch a read. Write wins if both are high.
  - Latch `address` and `wdata`, clear the phase index and wait counter, then go to ACCESS.
- **Offset:** `off` = `address` − `BASE_ADDR`, computed at 32 bits.
- **Read:**
  - Base halfword = {`off`[18:3], 2'b00}.
  - 4 phases, k=0..3, with `SRAM_ADDR` = base+k.
  - At the last cycle of phase k, capture `SRAM_DQ` into `rdata`[16k+15:16k]. The line is 8-byte aligned, so the word at `off`[2]=1 is returned in `rdata`[63:32].
- **Write:**
  - Base halfword = {`off`[18:2], 1'b0}.
  - 2 phases: phase 0 drives `wdata`[15:0] at base; phase 1 drives `wdata`[31:16] at base+1.
- **Phase sequencing:** a wait counter counts 0..`WAIT_CYCLES`. When it wraps, advance the phase. After the last phase, go to DONE.
- **DONE:** `ready`=1 for exactly this one cycle, then return to IDLE unconditionally. Requests still high during DONE are ignored. A new request is first considered in IDLE.
- **Strobes in ACCESS:**
  - `SRAM_CE_N`=0, `SRAM_UB_N`=0, `SRAM_LB_N`=0.
  - `SRAM_OE_N`=0 on reads; `SRAM_WE_N`=0 on writes.
- **Strobes in IDLE and DONE:** all strobes are 1 and `SRAM_DQ` is Z.
- `rdata` holds its value between reads. Writes never modify `rdata`.
- Addresses with `off` ≥ 2^19 wrap modulo 2^19 through bit truncation. This also applies to addresses below `BASE_ADDR`, unless the range check is compiled in.

## Timing
- **Reset values:** state IDLE, `rdata`=0, `ready`=0, `err`=0, `SRAM_ADDR`=0, all strobes 1, `SRAM_DQ` Z.
- **Reset mid-access:** the access is abandoned immediately with no `ready` pulse. Strobes return to 1 asynchronously.
- **Read latency:** counting the first ACCESS cycle as cycle 1, `ready` is high in cycle 4·(`WAIT_CYCLES`+1)+1. With defaults, that is cycle 9.
- **Write latency:** `ready` is high in cycle 2·(`WAIT_CYCLES`+1)+1. With defaults, that is cycle 5.
- `rdata` is valid in the `ready` cycle; the final halfword is registered at the edge entering DONE.
- `SRAM_ADDR` and `SRAM_DQ` are registered outputs, stable for a whole phase.
- **Minimum spacing:** one idle cycle between back-to-back accesses (DONE → IDLE → ACCESS).

## Configuration
- **`SRAM_RANGE_CHECK_EN` defined:**
  - In IDLE, a request with `address` < `BASE_ADDR` or `off` ≥ 2^19 goes directly to DONE.
  - No strobe is asserted, `rdata` is unchanged, and `err`=1 together with `ready` for that single cycle. `err` is 0 at all other times.
- **Not defined:** the `err` port and check logic are absent; out-of-range addresses wrap as described in Operation.

## Test plan
- **Reset then idle:** `rst` pulse → all strobes 1, `SRAM_DQ` Z, `rdata`=0, `ready`=0 for 20 idle cycles.
- **Word write:** write `address`=0x414, `wdata`=0xDEADBEEF (defaults) → halfword 10 gets 0xBEEF and halfword 11 gets 0xDEAD, `SRAM_WE_N` low for cycles 1-4, `ready` in cycle 5.
- **Line read after write:** read `address`=0x410 → `SRAM_ADDR` 8,9,10,11 for two cycles each, `ready` in cycle 9, `rdata`[63:32]=0xDEADBEEF.
- **Write priority:** `read` and `write` both high at 0x420 → write phases only, `SRAM_OE_N` stays 1.
- **Reset mid-read:** `rst` asserted in cycle 4 of a read → no `ready` pulse, IDLE, `rdata`=0; the next read completes normally.
- **Range check:** with `SRAM_RANGE_CHECK_EN`, read 0x3FC → `ready`=1 and `err`=1 in the cycle after acceptance, no strobes asserted, `rdata` unchanged.
